// File: rtl/nios2_system_pio_pkg.sv
// Shared constants for the edge-capturing Nios II parallel input port.
// Register map, reset values and read-mux width.
package nios2_system_pio_pkg;

  localparam int unsigned RD_W = 32;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN   = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN   = 3'd4;
  localparam logic [2:0] ADDR_DEB_LIMIT = 3'd5;

  localparam logic [RD_W-1:0] RISE_EN_RST  = '0;
  localparam logic [RD_W-1:0] IRQ_MASK_RST = '0;
  localparam logic [RD_W-1:0] FALL_EN_RST  = '1;

endpackage

// File: rtl/nios2_system_pio_debounce.sv
// One input channel: reset-to-0 synchroniser chain followed by an
// optional stability filter (PIO_DEBOUNCE_EN).
module nios2_system_pio_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_in,
  input  logic [DEB_W-1:0] i_limit,
  output logic             o_filt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  logic [DEB_W-1:0] r_cnt;
  logic             r_filt;

  // filt follows sync only after limit+1 consecutive differing cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_sync == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == i_limit) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_filt = r_filt;
`else
  logic w_unused_limit;
  assign w_unused_limit = ^i_limit;
  assign o_filt = w_sync;
`endif

endmodule

// File: rtl/nios2_system_pio_irq_n.sv
// Avalon-MM edge-capture PIO with maskable irq; the optional per-bit
// debounce filter is compiled in with PIO_DEBOUNCE_EN.
module nios2_system_pio_irq_n
  import nios2_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [DEB_W-1:0] w_lim;
  logic [RD_W-1:0]  w_rd;
  logic             w_unused_wd;

  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_prev;
  logic [RD_W-1:0]  r_rd;

  assign w_wr        = chipselect && !write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_unused_wd = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    nios2_system_pio_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_W      (DEB_W)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .i_in   (in_port[g]),
      .i_limit(w_lim),
      .o_filt (w_filt[g])
    );
  end

`ifdef PIO_DEBOUNCE_EN
  logic [DEB_W-1:0] r_lim;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lim <= '0;
    end else if (w_wr && address == ADDR_DEB_LIMIT) begin
      r_lim <= writedata[DEB_W-1:0];
    end
  end

  assign w_lim = r_lim;
`else
  assign w_lim = '0;
`endif

  assign w_set = (w_filt & ~r_prev & r_rise_en)
               | (~w_filt & r_prev & r_fall_en);
  assign w_clr = (w_wr && address == ADDR_EDGE_CAP) ? w_wd : '0;

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      (address == ADDR_DATA):      w_rd[WIDTH-1:0] = w_filt;
      (address == ADDR_RISE_EN):   w_rd[WIDTH-1:0] = r_rise_en;
      (address == ADDR_IRQ_MASK):  w_rd[WIDTH-1:0] = r_mask;
      (address == ADDR_EDGE_CAP):  w_rd[WIDTH-1:0] = r_cap;
      (address == ADDR_FALL_EN):   w_rd[WIDTH-1:0] = r_fall_en;
      (address == ADDR_DEB_LIMIT): w_rd[DEB_W-1:0] = w_lim;
      default:                     w_rd = '0;
    endcase
  end

  // set is OR'd after the clear so a same-cycle edge is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise_en <= RISE_EN_RST[WIDTH-1:0];
      r_fall_en <= FALL_EN_RST[WIDTH-1:0];
      r_mask    <= IRQ_MASK_RST[WIDTH-1:0];
      r_cap     <= '0;
      r_prev    <= '0;
      r_rd      <= '0;
    end else begin
      r_prev <= w_filt;
      r_cap  <= (r_cap & ~w_clr) | w_set;
      r_rd   <= w_rd;
      if (w_wr) begin
        unique case (1'b1)
          (address == ADDR_RISE_EN):  r_rise_en <= w_wd;
          (address == ADDR_IRQ_MASK): r_mask    <= w_wd;
          (address == ADDR_FALL_EN):  r_fall_en <= w_wd;
          default: ;
        endcase
      end
    end
  end

  assign readdata = r_rd;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_nios2_system_pio_irq_n.sv
// Self-checking bench for nios2_system_pio_irq_n (default parameters).
// Works with or without PIO_DEBOUNCE_EN defined.
module tb_nios2_system_pio_irq_n;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int DW = 16;
`ifdef PIO_DEBOUNCE_EN
  localparam int DEB_X = 1;
`else
  localparam int DEB_X = 0;
`endif
  localparam int LAT = S + 1 + DEB_X;

  logic          clk;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int n_chk;
  int n_err;
  bit cmp_on;

  nios2_system_pio_irq_n #(
    .WIDTH(W), .SYNC_STAGES(S), .DEB_W(DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: input history window, register file, capture set
  logic [W-1:0] m_hist [0:63];
  logic [W-1:0] m_prev, m_rise, m_fall, m_mask, m_cap;
  logic [31:0]  m_rd;
`ifdef PIO_DEBOUNCE_EN
  logic [W-1:0]  m_filt_r;
  logic [DW-1:0] m_lim;

  function automatic logic [W-1:0] f_deb_next();
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      bit stable = 1'b1;
      for (int k = 0; k <= int'(m_lim) && k < 60; k++)
        if (m_hist[S-1+k][b] == m_filt_r[b]) stable = 1'b0;
      r[b] = stable ? ~m_filt_r[b] : m_filt_r[b];
    end
    return r;
  endfunction
`endif

  function automatic logic [W-1:0] f_filt();
`ifdef PIO_DEBOUNCE_EN
    return m_filt_r;
`else
    return m_hist[S-1];
`endif
  endfunction

  function automatic logic [W-1:0] f_set();
    logic [W-1:0] f = f_filt();
    return (f & ~m_prev & m_rise) | (~f & m_prev & m_fall);
  endfunction

  function automatic logic [W-1:0] f_clr();
    if (chipselect && !write_n && address == 3'd3)
      return writedata[W-1:0];
    return '0;
  endfunction

  function automatic logic [31:0] f_rd(input logic [2:0] a);
    case (a)
      3'd0: return 32'(f_filt());
      3'd1: return 32'(m_rise);
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_cap);
      3'd4: return 32'(m_fall);
`ifdef PIO_DEBOUNCE_EN
      3'd5: return 32'(m_lim);
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) m_hist[i] <= '0;
      m_prev <= '0;
      m_rise <= '0;
      m_fall <= '1;
      m_mask <= '0;
      m_cap  <= '0;
      m_rd   <= '0;
`ifdef PIO_DEBOUNCE_EN
      m_filt_r <= '0;
      m_lim    <= '0;
`endif
    end else begin
      m_hist[0] <= in_port;
      for (int i = 1; i < 64; i++) m_hist[i] <= m_hist[i-1];
`ifdef PIO_DEBOUNCE_EN
      m_filt_r <= f_deb_next();
`endif
      m_prev <= f_filt();
      m_cap  <= (m_cap & ~f_clr()) | f_set();
      m_rd   <= f_rd(address);
      if (chipselect && !write_n) begin
        case (address)
          3'd1: m_rise <= writedata[W-1:0];
          3'd2: m_mask <= writedata[W-1:0];
          3'd4: m_fall <= writedata[W-1:0];
`ifdef PIO_DEBOUNCE_EN
          3'd5: m_lim  <= writedata[DW-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  logic [31:0] v;

  initial begin
    n_chk = 0;
    n_err = 0;
    cmp_on = 1'b0;
    reset_n = 1'b0;
    address = '0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    in_port = '0;

    fork
      forever begin
        @(negedge clk);
        if (cmp_on) begin
          chk("cmp_readdata", readdata, m_rd);
          chk("cmp_irq", 32'(irq), 32'(|(m_cap & m_mask)));
        end
      end
    join_none

    // reset defaults
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      chk($sformatf("rst_reg%0d", a), v, (a == 4) ? 32'hFF : 32'h0);
    end

    // falling edge, default enables
    in_port[0] = 1'b1;
    repeat (6) @(negedge clk);
    wr(3'd2, 32'h01);
    in_port[0] = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk("fall_irq_early", 32'(irq), 32'h0);
    @(negedge clk);
    chk("fall_irq", 32'(irq), 32'h1);
    rd(3'd3, v);
    chk("fall_cap", v, 32'h01);
    wr(3'd3, 32'h01);
    chk("fall_clr_irq", 32'(irq), 32'h0);
    rd(3'd3, v);
    chk("fall_clr_cap", v, 32'h00);

    // any-edge on bit 7, 5-cycle pulse
    wr(3'd1, 32'h80);
    wr(3'd4, 32'h80);
    wr(3'd2, 32'h80);
    in_port[7] = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("any_rise_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h80);
    chk("any_rise_clr", 32'(irq), 32'h0);
    in_port[7] = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("any_fall_irq", 32'(irq), 32'h1);
    rd(3'd3, v);
    chk("any_fall_cap", v, 32'h80);
    wr(3'd3, 32'h80);
    chk("any_fall_clr", 32'(irq), 32'h0);
    for (int i = 0; i < 6; i++) begin
      in_port[6] = ~in_port[6];
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    rd(3'd3, v);
    chk("bit6_nocap", v, 32'h00);

    // W1C in the same cycle as a new edge on bit 2
    wr(3'd1, 32'h04);
    wr(3'd4, 32'h04);
    in_port[2] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    rd(3'd3, v);
    chk("sim_pre_cap", v, 32'h04);
    in_port[2] = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd3;
    writedata  = 32'h04;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd(3'd3, v);
    chk("sim_cap_kept", v, 32'h04);
    wr(3'd3, 32'h04);
    rd(3'd3, v);
    chk("sim_cap_clr", v, 32'h00);

`ifdef PIO_DEBOUNCE_EN
    wr(3'd5, 32'd4);
    rd(3'd5, v);
    chk("deb_limit_rb", v, 32'd4);
    wr(3'd1, 32'h02);
    wr(3'd2, 32'h02);
    in_port[1] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b0;
    repeat (12) @(negedge clk);
    rd(3'd0, v);
    chk("deb_glitch_data", v, 32'h00);
    rd(3'd3, v);
    chk("deb_glitch_cap", v, 32'h00);
    in_port[1] = 1'b1;
    repeat (S + 4 + 1) @(negedge clk);
    chk("deb_irq_early", 32'(irq), 32'h0);
    @(negedge clk);
    chk("deb_irq", 32'(irq), 32'h1);
    rd(3'd0, v);
    chk("deb_data", v, 32'h02);
    wr(3'd5, 32'd0);
`else
    wr(3'd5, 32'd4);
    rd(3'd5, v);
    chk("deb_limit_ro", v, 32'd0);
`endif

    // mid-operation reset
    wr(3'd1, 32'hFF);
    wr(3'd4, 32'hFF);
    wr(3'd2, 32'hFF);
    in_port = 8'h00;
    repeat (10) @(negedge clk);
    in_port = 8'hFF;
    repeat (10) @(negedge clk);
    rd(3'd3, v);
    chk("pre_rst_cap", v, 32'hFF);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    in_port = 8'h0F;
    #1;
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_rd", readdata, 32'h0);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd1;
    writedata  = 32'h0F;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (6) @(negedge clk);
    rd(3'd3, v);
    chk("post_rst_cap", v, 32'h0F);
    chk("post_rst_irq", 32'(irq), 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
